// File: rtl/axis_rr_arbiter_4_if.sv
// Handshake and select bundle between the 4:1 AXI-Stream mux and its round-robin arbiter.
// The master side owns the source valids and the downstream ready; the slave side is the arbiter.
interface axis_rr_arbiter_4_if #(
  parameter int SEL_W = 2,
  parameter int CNT_W = 8
);
  logic [3:0]       req;
  logic [SEL_W-1:0] sel;
  logic             valid_in;
  logic             ready_out;
  logic             valid_out;
  logic             ready_in;
  logic             grant_active;
  logic [CNT_W-1:0] beat_cnt;

  modport master (
    output req, valid_in, ready_in,
    input  sel, ready_out, valid_out, grant_active, beat_cnt
  );

  modport slave (
    input  req, valid_in, ready_in,
    output sel, ready_out, valid_out, grant_active, beat_cnt
  );
endinterface

// File: rtl/axis_rr_arbiter_4.sv
// Round-robin burst arbiter for a 4:1 AXI-Stream mux: holds the select for up to MAX_BURST
// beats or until the granted source goes idle, and gates valid/ready while no grant is held.
module axis_rr_arbiter_4 #(
  parameter int SEL_W     = 2,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  axis_rr_arbiter_4_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_sel_next;
  logic [SEL_W-1:0] r_rr_ptr;
  logic [SEL_W-1:0] w_rr_ptr_next;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] w_beat_cnt_next;

  logic             w_grant_active;
  logic             w_xfer;
  logic             w_last_beat;
  logic             w_release;
  logic [7:0]       w_req_dbl;
  logic [3:0]       w_req_rot;
  logic             w_pick_found;
  logic [SEL_W-1:0] w_pick_off;
  logic [SEL_W-1:0] w_pick;

  assign w_grant_active = (r_state == GRANT);
  assign w_xfer         = bus.valid_in & bus.ready_in & w_grant_active;
  assign w_last_beat    = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
  assign w_release      = (w_xfer & w_last_beat) | ~bus.req[r_sel];

  // Rotate req so bit 0 is the source at rr_ptr; the lowest set bit is then the next in turn.
  assign w_req_dbl = {bus.req, bus.req};
  assign w_req_rot = w_req_dbl[r_rr_ptr +: 4];

  always_comb begin
    w_pick_off   = '0;
    w_pick_found = |w_req_rot;
    for (int k = 3; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_pick_off = SEL_W'(k);
      end
    end
  end

  assign w_pick = r_rr_ptr + w_pick_off;

  always_comb begin
    w_state_next    = r_state;
    w_sel_next      = r_sel;
    w_rr_ptr_next   = r_rr_ptr;
    w_beat_cnt_next = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_state_next    = GRANT;
          w_sel_next      = w_pick;
          w_rr_ptr_next   = w_pick + 1'b1;
          w_beat_cnt_next = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          // Back-to-back regrant avoids a bubble when anyone else is waiting.
          if (w_pick_found) begin
            w_sel_next      = w_pick;
            w_rr_ptr_next   = w_pick + 1'b1;
            w_beat_cnt_next = '0;
          end else begin
            w_state_next = IDLE;
          end
        end else if (w_xfer) begin
          w_beat_cnt_next = r_beat_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_sel      <= w_sel_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_beat_cnt <= w_beat_cnt_next;
    end
  end

  assign bus.sel          = r_sel;
  assign bus.beat_cnt     = r_beat_cnt;
  assign bus.grant_active = w_grant_active;
  assign bus.valid_out    = bus.valid_in & w_grant_active;
  assign bus.ready_out    = bus.ready_in & w_grant_active;

endmodule

// File: tb/tb_axis_rr_arbiter_4.sv
// Directed vector bench for axis_rr_arbiter_4 with MAX_BURST=4: a table of per-cycle
// inputs and expected outputs, plus a hand-written burst sequence with a stuttering sink.
module tb_axis_rr_arbiter_4;

  logic clk;
  logic rst_n;

  axis_rr_arbiter_4_if #(.SEL_W(2), .CNT_W(8)) bus ();

  axis_rr_arbiter_4 #(.SEL_W(2), .MAX_BURST(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         scn;
    logic       rst;
    logic [3:0] req;
    logic       vi;
    logic       ri;
    logic [1:0] sel;
    logic       ga;
    logic       vo;
    logic       ro;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  task automatic add(input int scn, input logic rst, input logic [3:0] rq, input logic vi,
                     input logic ri, input logic [1:0] s, input logic ga, input logic [7:0] c);
    vec_t v;
    v.scn = scn; v.rst = rst; v.req = rq; v.vi = vi; v.ri = ri;
    v.sel = s; v.ga = ga; v.vo = vi & ga; v.ro = ri & ga; v.cnt = c;
    vecs.push_back(v);
  endtask

  // A beat must never cross while no grant is held.
  always @(negedge clk) begin
    #2;
    if (rst_n && bus.valid_out && bus.ready_in && !bus.grant_active) begin
      n_bad++;
      $display("FAIL xfer_without_grant t=%0t valid_out=%0b ready_in=%0b grant_active=0",
               $time, bus.valid_out, bus.ready_in);
    end
  end

  initial begin
    int xfers_on_1;
    int cycles;
    bit reached;

    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.req = 4'b0000;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;

    // 1: single requester, 4-beat burst, then regrant with no idle cycle
    add(1, 0, 4'b0001, 1, 1, 0, 0, 0);
    add(1, 1, 4'b0001, 1, 1, 0, 0, 0);
    for (int c = 0; c < 4; c++) add(1, 1, 4'b0001, 1, 1, 0, 1, 8'(c));
    add(1, 1, 4'b0001, 1, 1, 0, 1, 0);

    // 2: all requesting, rotation 0,1,2,3,0 with 4 beats each
    add(2, 0, 4'b0000, 0, 0, 0, 0, 0);
    add(2, 1, 4'b1111, 1, 1, 0, 0, 0);
    for (int g = 0; g < 4; g++)
      for (int c = 0; c < 4; c++) add(2, 1, 4'b1111, 1, 1, 2'(g), 1, 8'(c));
    add(2, 1, 4'b1111, 1, 1, 0, 1, 0);

    // 3: sel=2 stalled 10 cycles, nothing moves; then one beat
    add(3, 0, 4'b0000, 0, 0, 0, 0, 0);
    add(3, 1, 4'b0100, 1, 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) add(3, 1, 4'b0100, 1, 0, 2, 1, 0);
    add(3, 1, 4'b0100, 1, 1, 2, 1, 0);
    add(3, 1, 4'b0100, 1, 1, 2, 1, 1);

    // 4: sel=1 after 2 beats, source 1 goes idle, req=1001 -> sel=3
    add(4, 0, 4'b0000, 0, 0, 0, 0, 0);
    add(4, 1, 4'b0010, 1, 1, 0, 0, 0);
    add(4, 1, 4'b0010, 1, 1, 1, 1, 0);
    add(4, 1, 4'b0010, 1, 1, 1, 1, 1);
    add(4, 1, 4'b1001, 0, 1, 1, 1, 2);
    add(4, 1, 4'b1001, 1, 1, 3, 1, 0);

    // 5: idle with stale sel, valid_in/ready_in high -> nothing passes
    add(5, 0, 4'b0000, 1, 1, 0, 0, 0);
    add(5, 1, 4'b0000, 1, 1, 0, 0, 0);
    add(5, 1, 4'b0000, 1, 1, 0, 0, 0);

    // 6: reset mid-burst at beat_cnt=2, then req=0100 -> sel=2
    add(6, 1, 4'b0010, 1, 1, 0, 0, 0);
    add(6, 1, 4'b0010, 1, 1, 1, 1, 0);
    add(6, 1, 4'b0010, 1, 1, 1, 1, 1);
    add(6, 0, 4'b0010, 1, 1, 0, 0, 0);
    add(6, 1, 4'b0100, 1, 1, 0, 0, 0);
    add(6, 1, 4'b0100, 1, 1, 2, 1, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n        = vecs[i].rst;
      bus.req      = vecs[i].req;
      bus.valid_in = vecs[i].vi;
      bus.ready_in = vecs[i].ri;
      #1;
      n_vec++;
      if (bus.sel !== vecs[i].sel || bus.grant_active !== vecs[i].ga ||
          bus.valid_out !== vecs[i].vo || bus.ready_out !== vecs[i].ro ||
          bus.beat_cnt !== vecs[i].cnt) begin
        n_bad++;
        $display("FAIL vec%0d scn%0d got sel=%0d ga=%0b vo=%0b ro=%0b cnt=%0d want sel=%0d ga=%0b vo=%0b ro=%0b cnt=%0d",
                 i, vecs[i].scn, bus.sel, bus.grant_active, bus.valid_out, bus.ready_out,
                 bus.beat_cnt, vecs[i].sel, vecs[i].ga, vecs[i].vo, vecs[i].ro, vecs[i].cnt);
      end
    end

    // Stuttering sink: grant on source 1 must carry exactly 4 xfers, then move to source 3.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n        = 1'b1;
    bus.req      = 4'b1010;
    bus.valid_in = 1'b1;
    bus.ready_in = 1'b1;
    xfers_on_1 = 0;
    reached    = 1'b0;
    cycles     = 0;
    while (!reached && cycles < 40) begin
      @(negedge clk);
      bus.ready_in = ~bus.ready_in;
      #1;
      cycles++;
      if (bus.grant_active && bus.sel == 2'd3) reached = 1'b1;
      else if (bus.grant_active && bus.sel == 2'd1 && bus.valid_out && bus.ready_in)
        xfers_on_1++;
    end
    n_vec++;
    if (!reached) begin
      n_bad++;
      $display("FAIL stutter_rotate got no grant on sel=3 within 40 cycles, want sel=3");
    end
    n_vec++;
    if (xfers_on_1 != 4) begin
      n_bad++;
      $display("FAIL stutter_burst got %0d xfers on sel=1, want 4", xfers_on_1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
